alu_ctrl: RTL and testbench

Command-driven sequencer for the 16-bit ALU. It sits between the instruction decoder and the ALU/register-file pair. It accepts one ALU command at a time over a valid/ready handshake and drives the register-file read and write addresses, the ALU `aluc` and `cy_in` inputs, and the write enable. It owns the architectural carry flag and runs two-pass 32-bit adds.

---
 rtl/alu_ctrl_if.sv | 20 ++
 rtl/alu_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Command channel between the instruction decoder (master) and the ALU sequencer (slave).
// A command transfers on a rising edge where cmd_valid && cmd_ready; the payload is only meaningful while cmd_valid is high.
interface alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [2:0] cmd_ra;
  logic [2:0] cmd_rb;
  logic [2:0] cmd_rd;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd,
    output cmd_ready
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencer for the 16-bit ALU: latches one command, drives register-file and ALU controls,
// owns the architectural carry flag and splits ADD32 into a low ADD pass and a high ADC pass.
module alu_ctrl (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_if.slave        cmd,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  output logic [2:0]       rf_waddr,
  output logic             rf_we,
  output logic [3:0]       alu_aluc,
  output logic             alu_cy_in,
  input  logic             alu_cy_out,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_EXEC_HI = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_ADC   = 4'd5;
  localparam logic [3:0] OP_LAST  = 4'd10;
  localparam logic [3:0] OP_CLC   = 4'd11;
  localparam logic [3:0] OP_SEC   = 4'd12;
  localparam logic [3:0] OP_ADD32 = 4'd13;

  logic [1:0] state_q, state_d;
  logic [3:0] op_q;
  logic [2:0] ra_q, rb_q, rd_q;
  logic       carry_q, carry_d;
  logic       ready;
  logic       accept;
  logic       we_c;

  assign ready         = (state_q == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && ready;
  assign cmd.cmd_ready = ready;

  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    rf_raddr_a = 3'd0;
    rf_raddr_b = 3'd0;
    rf_waddr   = 3'd0;
    we_c       = 1'b0;
    alu_aluc   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        rf_raddr_a = ra_q;
        rf_raddr_b = rb_q;
        rf_waddr   = rd_q;
        state_d    = S_DONE;
        if (op_q <= OP_LAST) begin
          alu_aluc = op_q;
          we_c     = 1'b1;
          if (op_q == OP_ADD || op_q == OP_ADC) carry_d = alu_cy_out;
        end else if (op_q == OP_CLC) begin
          carry_d = 1'b0;
        end else if (op_q == OP_SEC) begin
          carry_d = 1'b1;
        end else if (op_q == OP_ADD32) begin
          alu_aluc = OP_ADD;
          we_c     = 1'b1;
          carry_d  = alu_cy_out;
          state_d  = S_EXEC_HI;
        end
      end
      S_EXEC_HI: begin
        // High word reads after the low write has landed, so rd aliasing ra+1/rb+1 sees the new value.
        rf_raddr_a = ra_q + 3'd1;
        rf_raddr_b = rb_q + 3'd1;
        rf_waddr   = rd_q + 3'd1;
        alu_aluc   = OP_ADC;
        we_c       = 1'b1;
        carry_d    = alu_cy_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      op_q    <= 4'd0;
      ra_q    <= 3'd0;
      rb_q    <= 3'd0;
      rd_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      if (accept) begin
        op_q <= cmd.cmd_op;
        ra_q <= cmd.cmd_ra;
        rb_q <= cmd.cmd_rb;
        rd_q <= cmd.cmd_rd;
      end
    end
  end

  // Reset gates the write strobe so an aborted command cannot commit on the reset edge.
  assign rf_we       = we_c && !rst;
  assign alu_cy_in   = carry_q;
  assign carry       = carry_q;
  assign busy        = (state_q != S_IDLE) && !rst;
  assign done        = (state_q == S_DONE) && !rst;
  assign err         = done && (op_q > OP_ADD32);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU + register file around the DUT, architectural
// reference model feeding an expected queue, and a negedge monitor that retires entries on done.
module tb_alu_ctrl;
  localparam int W = 39; // {err, carry, nwr[1:0], rd[2:0], r(rd+1)[15:0], r(rd)[15:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we;
  logic [3:0]  alu_aluc;
  logic        alu_cy_in, alu_cy_out;
  logic        carry, busy, done, err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  alu_ctrl_if cmd ();

  alu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .alu_aluc   (alu_aluc),
    .alu_cy_in  (alu_cy_in),
    .alu_cy_out (alu_cy_out),
    .carry      (carry),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  // ALU environment: carry-out outside ADD/ADC is deliberately data-dependent noise.
  function automatic logic [16:0] alu_fn(input logic [3:0] f, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    logic [16:0] r;
    r = {^{a, b}, 16'h0000};
    case (f)
      4'd0:  r[15:0] = a;
      4'd1:  r[15:0] = b;
      4'd2:  r[15:0] = ~a;
      4'd3:  r[15:0] = a | b;
      4'd4:  r = {1'b0, a} + {1'b0, b};
      4'd5:  r = {1'b0, a} + {1'b0, b} + {16'h0000, c};
      4'd6:  r[15:0] = a - b;
      4'd7:  r[15:0] = a & b;
      4'd8:  r[15:0] = a ^ b;
      4'd9:  r[15:0] = a << 1;
      4'd10: r[15:0] = a >> 1;
      default: r[15:0] = 16'h0000;
    endcase
    return r;
  endfunction

  logic [15:0] rf [8];
  logic [15:0] pre_vals [8];
  logic        pre_en = 1'b0;
  logic [16:0] alu_r;

  always_comb alu_r = alu_fn(alu_aluc, rf[rf_raddr_a], rf[rf_raddr_b], alu_cy_in);
  assign alu_cy_out = alu_r[16];

  always @(posedge clk) begin
    if (pre_en) rf <= pre_vals;
    else if (rf_we) rf[rf_waddr] <= alu_r[15:0];
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [15:0]  ref_rf [8];
  logic         ref_carry;
  int           checks = 0;
  int           errors = 0;
  int           wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: effect of one command on the eight registers and the carry flag.
  task automatic model_cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, output int lat);
    logic [16:0] lo, hi;
    logic [1:0]  nwr;
    logic        e;
    logic [2:0]  rd1;
    nwr = 2'd0; e = 1'b0; lat = 2; rd1 = rd + 3'd1;
    if (op <= 4'd10) begin
      lo = alu_fn(op, ref_rf[ra], ref_rf[rb], ref_carry);
      ref_rf[rd] = lo[15:0];
      if (op == 4'd4 || op == 4'd5) ref_carry = lo[16];
      nwr = 2'd1;
    end else if (op == 4'd11) begin
      ref_carry = 1'b0;
    end else if (op == 4'd12) begin
      ref_carry = 1'b1;
    end else if (op == 4'd13) begin
      lo = {1'b0, ref_rf[ra]} + {1'b0, ref_rf[rb]};
      ref_rf[rd] = lo[15:0];
      hi = {1'b0, ref_rf[ra + 3'd1]} + {1'b0, ref_rf[rb + 3'd1]} + {16'h0000, lo[16]};
      ref_rf[rd1] = hi[15:0];
      ref_carry = hi[16];
      nwr = 2'd2;
      lat = 3;
    end else begin
      e = 1'b1;
    end
    exp_q.push_back({e, ref_carry, nwr, rd, ref_rf[rd1], ref_rf[rd]});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   erd, erd1;
    if (rst === 1'b1) begin
      chk("reset_outputs", {27'd0, rf_we, done, err, busy, cmd.cmd_ready}, 32'd0);
      wr_cnt = 0;
    end else if (rst === 1'b0) begin
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, !cmd.cmd_ready});
      chk("cy_in_tracks_carry", {31'd0, alu_cy_in}, {31'd0, carry});
      chk("err_only_with_done", {31'd0, err & ~done}, 32'd0);
      if (rf_we) wr_cnt++;
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_expected: got done with empty queue at %0t", $time);
        end else begin
          e    = exp_q.pop_front();
          erd  = e[34:32];
          erd1 = erd + 3'd1;
          chk("err_flag",  {31'd0, err},   {31'd0, e[38]});
          chk("carry",     {31'd0, carry}, {31'd0, e[37]});
          chk("num_writes", wr_cnt,        {30'd0, e[36:35]});
          chk("r_rd",      {16'd0, rf[erd]},  {16'd0, e[15:0]});
          chk("r_rd_plus1",{16'd0, rf[erd1]}, {16'd0, e[31:16]});
        end
        wr_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync_regs();
    pre_vals = ref_rf;
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'($urandom);
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input bit hold);
    int n;
    int lat;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = op; cmd.cmd_ra = ra; cmd.cmd_rb = rb; cmd.cmd_rd = rd;
    n = 0;
    @(negedge clk);
    while (!cmd.cmd_ready && n < 20) begin n++; @(negedge clk); end
    chk("ready_wait", {31'd0, cmd.cmd_ready}, 32'd1);
    if (!cmd.cmd_ready) begin
      cmd.cmd_valid = 1'b0;
      return;
    end
    model_cmd(op, ra, rb, rd, lat);
    @(posedge clk); #1;
    if (hold) begin
      cmd.cmd_op = 4'($urandom); cmd.cmd_ra = 3'($urandom);
      cmd.cmd_rb = 3'($urandom); cmd.cmd_rd = 3'($urandom);
    end else begin
      cmd.cmd_valid = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 8);
    chk("done_latency", n, lat);
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] lo;
    rst = 1'b1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = 4'd4; cmd.cmd_ra = 3'd1; cmd.cmd_rb = 3'd2; cmd.cmd_rd = 3'd3;
    ref_carry = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmd.cmd_valid = 1'b0;
    @(negedge clk);
    chk("reset_carry", {31'd0, carry}, 32'd0);
    chk("reset_ready", {31'd0, cmd.cmd_ready}, 32'd1);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;

    // Plain ADD
    rand_regs();
    ref_rf[1] = 16'h1234; ref_rf[2] = 16'h0F0F;
    sync_regs();
    send(4'd4, 3'd1, 3'd2, 3'd3, 1'b0);

    // ADD producing carry, then ADC consuming it
    ref_rf[1] = 16'hFFFF; ref_rf[2] = 16'h0001; ref_rf[4] = 16'h0000; ref_rf[5] = 16'h0000;
    sync_regs();
    send(4'd4, 3'd1, 3'd2, 3'd3, 1'b0);
    send(4'd5, 3'd4, 3'd5, 3'd6, 1'b0);

    // ADD32 into r5:r4, then wrapping into r0:r7
    ref_rf[0] = 16'hFFFF; ref_rf[1] = 16'h0001; ref_rf[2] = 16'h0001; ref_rf[3] = 16'h0002;
    sync_regs();
    send(4'd13, 3'd0, 3'd2, 3'd4, 1'b0);
    send(4'd13, 3'd0, 3'd2, 3'd7, 1'b0);

    // Carry flag ops around an AND
    send(4'd12, 3'd1, 3'd2, 3'd3, 1'b0);
    send(4'd7,  3'd1, 3'd2, 3'd5, 1'b0);
    send(4'd11, 3'd1, 3'd2, 3'd3, 1'b0);

    // Illegal ops with cmd_valid held through busy
    send(4'd14, 3'd2, 3'd3, 3'd4, 1'b1);
    send(4'd12, 3'd0, 3'd0, 3'd0, 1'b1);
    send(4'd15, 3'd5, 3'd6, 3'd7, 1'b1);

    // ADD32 whose destination aliases a high-word source
    rand_regs();
    sync_regs();
    send(4'd13, 3'd0, 3'd4, 3'd1, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        rand_regs();
        sync_regs();
      end
      send(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
           bit'($urandom_range(0, 1)));
    end

    // Reset during the high pass of an ADD32: only the low word lands
    rand_regs();
    sync_regs();
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = 4'd13; cmd.cmd_ra = 3'd0; cmd.cmd_rb = 3'd1; cmd.cmd_rd = 3'd6;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd.cmd_ready}, 32'd1);
    lo = {1'b0, ref_rf[0]} + {1'b0, ref_rf[1]};
    ref_rf[6] = lo[15:0];
    ref_carry = 1'b0;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_in_hi", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after_rst", {31'd0, cmd.cmd_ready}, 32'd1);
    chk("abort_carry", {31'd0, carry}, 32'd0);
    chk("abort_low_word", {16'd0, rf[6]}, {16'd0, ref_rf[6]});
    chk("abort_high_untouched", {16'd0, rf[7]}, {16'd0, ref_rf[7]});
    repeat (4) @(negedge clk);
    chk("abort_no_done", {31'd0, done}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
